// File: rtl/clk_freq_monitor_if.sv
// rtl/clk_freq_monitor_if.sv - signal bundle between a clock-frequency monitor and its controller
// master drives monitored clocks, lock flags and configuration; slave is the monitor itself.
interface clk_freq_monitor_if #(
  parameter int NCLK   = 4,
  parameter int CNT_W  = 24,
  parameter int GATE_W = 24,
  parameter int UL_W   = 16
);
  logic [NCLK-1:0]       clk_test;
  logic [NCLK-1:0]       locked;
  logic [GATE_W-1:0]     gate_len;
  logic [NCLK*CNT_W-1:0] thr_lo;
  logic [NCLK*CNT_W-1:0] thr_hi;
  logic [NCLK-1:0]       clr;
  logic [NCLK*CNT_W-1:0] rate;
  logic                  update_stb;
  logic [NCLK-1:0]       in_range;
  logic [NCLK-1:0]       alarm_lo;
  logic [NCLK-1:0]       alarm_hi;
  logic [NCLK*UL_W-1:0]  unlocks;
  logic [NCLK-1:0]       lock_now;

  modport master (
    output clk_test, locked, gate_len, thr_lo, thr_hi, clr,
    input  rate, update_stb, in_range, alarm_lo, alarm_hi, unlocks, lock_now
  );

  modport slave (
    input  clk_test, locked, gate_len, thr_lo, thr_hi, clr,
    output rate, update_stb, in_range, alarm_lo, alarm_hi, unlocks, lock_now
  );
endinterface

// File: rtl/clk_freq_monitor.sv
// rtl/clk_freq_monitor.sv - gated edge counter measuring NCLK asynchronous clocks against clk_ref
// Counts synchronised rising edges per window, range-checks them and tracks PLL lock losses.
module clk_freq_monitor #(
  parameter int NCLK   = 4,
  parameter int CNT_W  = 24,
  parameter int GATE_W = 24,
  parameter int UL_W   = 16
) (
  input logic             clk_ref,
  input logic             aresetn,
  clk_freq_monitor_if.slave mon
);
  typedef enum logic [1:0] {IDLE = 2'd0, PRIME = 2'd1, RUN = 2'd2} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [UL_W-1:0]  UL_MAX  = '1;

  state_t            state, state_nxt;
  logic [NCLK-1:0]   ts1, ts2, ts3;
  logic [NCLK-1:0]   ls1, ls2, ls3;
  logic [NCLK-1:0]   tedge, lfall;
  logic [GATE_W-1:0] gate_q, win_cnt;
  logic              at_end, win_clr, reload, capture;
  logic [CNT_W-1:0]  cnt     [NCLK];
  logic [CNT_W-1:0]  cnt_nxt [NCLK];
  logic [CNT_W-1:0]  rate_q  [NCLK];
  logic [UL_W-1:0]   ul_q    [NCLK];
  logic [NCLK-1:0]   lo, hi;
  logic [NCLK-1:0]   in_range_q, alarm_lo_q, alarm_hi_q;
  logic              stb_q;

  // Third flop of each chain only serves edge detection.
  always_ff @(posedge clk_ref or negedge aresetn) begin
    if (!aresetn) begin
      ts1 <= '0; ts2 <= '0; ts3 <= '0;
      ls1 <= '0; ls2 <= '0; ls3 <= '0;
    end else begin
      ts1 <= mon.clk_test; ts2 <= ts1; ts3 <= ts2;
      ls1 <= mon.locked;   ls2 <= ls1; ls3 <= ls2;
    end
  end

  assign tedge  = ts2 & ~ts3;
  assign lfall  = ~ls2 & ls3;
  assign at_end = (win_cnt == gate_q - GATE_W'(1));

  always_ff @(posedge clk_ref or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (mon.gate_len != '0) state_nxt = PRIME;
      PRIME, RUN: begin
        if (mon.gate_len == '0)  state_nxt = IDLE;
        else if (at_end)         state_nxt = (mon.gate_len != gate_q) ? PRIME : RUN;
      end
      default:    state_nxt = IDLE;
    endcase
  end

  // A window only reports when gate_len was stable across the whole of it.
  always_comb begin
    win_clr = 1'b1;
    reload  = 1'b0;
    capture = 1'b0;
    case (state)
      IDLE:  reload = 1'b1;
      PRIME: begin win_clr = at_end; reload = at_end; end
      RUN: begin
        win_clr = at_end;
        reload  = at_end;
        capture = at_end && (mon.gate_len == gate_q);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_ref or negedge aresetn) begin
    if (!aresetn) begin
      win_cnt <= '0;
      gate_q  <= '0;
    end else begin
      win_cnt <= win_clr ? '0 : win_cnt + GATE_W'(1);
      if (reload) gate_q <= mon.gate_len;
    end
  end

  always_comb begin
    for (int i = 0; i < NCLK; i++) begin
      cnt_nxt[i] = (cnt[i] == CNT_MAX) ? CNT_MAX : cnt[i] + CNT_W'(tedge[i]);
      lo[i]      = cnt_nxt[i] < mon.thr_lo[i*CNT_W +: CNT_W];
      hi[i]      = (cnt_nxt[i] > mon.thr_hi[i*CNT_W +: CNT_W]) || (cnt_nxt[i] == CNT_MAX);
    end
  end

  always_ff @(posedge clk_ref or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < NCLK; i++) begin
        cnt[i]    <= '0;
        rate_q[i] <= '0;
        ul_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NCLK; i++) begin
        cnt[i] <= win_clr ? '0 : cnt_nxt[i];
        if (capture) rate_q[i] <= cnt_nxt[i];
        if (mon.clr[i])                    ul_q[i] <= '0;
        else if (lfall[i] && ul_q[i] != UL_MAX) ul_q[i] <= ul_q[i] + UL_W'(1);
      end
    end
  end

  // Setting an alarm takes priority over a coincident clear.
  always_ff @(posedge clk_ref or negedge aresetn) begin
    if (!aresetn) begin
      stb_q      <= 1'b0;
      in_range_q <= '0;
      alarm_lo_q <= '0;
      alarm_hi_q <= '0;
    end else begin
      stb_q      <= capture;
      if (capture) in_range_q <= ~lo & ~hi;
      alarm_lo_q <= (alarm_lo_q & ~mon.clr) | ({NCLK{capture}} & lo);
      alarm_hi_q <= (alarm_hi_q & ~mon.clr) | ({NCLK{capture}} & hi);
    end
  end

  for (genvar g = 0; g < NCLK; g++) begin : g_pack
    assign mon.rate[g*CNT_W +: CNT_W]  = rate_q[g];
    assign mon.unlocks[g*UL_W +: UL_W] = ul_q[g];
  end

  assign mon.update_stb = stb_q;
  assign mon.in_range   = in_range_q;
  assign mon.alarm_lo   = alarm_lo_q;
  assign mon.alarm_hi   = alarm_hi_q;
  assign mon.lock_now   = ls2;
endmodule
